// File: rtl/whack_round_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : whack_round_scheduler
// Description : Game session controller for whack-a-mole. Sequences start,
//               pattern request, timed rounds, hit/miss judgement, lives,
//               saturating score and high-score capture.
// Revision    : 1.0 - initial release
// ============================================================================
module whack_round_scheduler #(
  parameter int TICK_DIV   = 1000,
  parameter int ROUND_BASE = 5,
  parameter int GAP_TICKS  = 2,
  parameter int LIVES      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [6:0] i_hit_btn,
  input  logic       i_pat_ack,
  input  logic [6:0] i_pat_in,
  output logic       o_pat_req,
  output logic [6:0] o_mole,
  output logic       o_round_active,
  output logic [7:0] o_score,
  output logic [7:0] o_hiscore,
  output logic [1:0] o_lives,
  output logic [1:0] o_level,
  output logic       o_game_over,
  output logic       o_hit_pulse,
  output logic       o_miss_pulse
);

  localparam int c_PRESC_W = $clog2(TICK_DIV);
  localparam int c_RCNT_W  = $clog2(ROUND_BASE + 1);
  localparam int c_GCNT_W  = $clog2(GAP_TICKS + 1);

  localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICK_DIV - 1);
  localparam logic [c_PRESC_W-1:0] c_PRESC_ONE = c_PRESC_W'(1);
  localparam logic [c_RCNT_W-1:0]  c_RBASE     = c_RCNT_W'(ROUND_BASE);
  localparam logic [c_RCNT_W-1:0]  c_RCNT_ONE  = c_RCNT_W'(1);
  localparam logic [c_GCNT_W-1:0]  c_GAP       = c_GCNT_W'(GAP_TICKS);
  localparam logic [c_GCNT_W-1:0]  c_GCNT_ONE  = c_GCNT_W'(1);
  localparam logic [1:0]           c_LIVES     = 2'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_SHOW = 3'd2,
    S_GAP  = 3'd3,
    S_OVER = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_start_q, r_pat_req, r_round_active, r_game_over;
  logic                 r_hit_pulse, r_miss_pulse;
  logic [6:0]           r_hit_q, r_mole;
  logic [7:0]           r_score, r_hiscore;
  logic [1:0]           r_lives, r_level;
  logic [c_RCNT_W-1:0]  r_rcnt;
  logic [c_GCNT_W-1:0]  r_gcnt;
  logic [c_PRESC_W-1:0] r_presc;

  logic                 w_pat_req_nxt, w_hit_pulse_nxt, w_miss_pulse_nxt, w_miss;
  logic [6:0]           w_mole_nxt, w_hit_new;
  logic [7:0]           w_score_nxt, w_hiscore_nxt;
  logic [1:0]           w_lives_nxt;
  logic [c_RCNT_W-1:0]  w_rcnt_nxt;
  logic [c_GCNT_W-1:0]  w_gcnt_nxt;
  logic [c_PRESC_W-1:0] w_presc_nxt;
  logic                 w_start_edge, w_tick;

  // Difficulty bands by score.
  function automatic logic [1:0] level_of(input logic [7:0] s);
    if (s < 8'd5)       level_of = 2'd0;
    else if (s < 8'd10) level_of = 2'd1;
    else if (s < 8'd20) level_of = 2'd2;
    else                level_of = 2'd3;
  endfunction

  assign w_start_edge = i_start & ~r_start_q;
  assign w_hit_new    = i_hit_btn & ~r_hit_q;
  assign w_tick       = (r_presc == c_PRESC_MAX);

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    w_state_nxt      = r_state;
    w_pat_req_nxt    = r_pat_req;
    w_mole_nxt       = r_mole;
    w_score_nxt      = r_score;
    w_hiscore_nxt    = r_hiscore;
    w_lives_nxt      = r_lives;
    w_hit_pulse_nxt  = 1'b0;
    w_miss_pulse_nxt = 1'b0;
    w_rcnt_nxt       = r_rcnt;
    w_gcnt_nxt       = r_gcnt;
    w_presc_nxt      = w_tick ? '0 : r_presc + c_PRESC_ONE;
    w_miss           = 1'b0;
    case (r_state)
      S_IDLE, S_OVER: begin
        if (w_start_edge) begin
          w_score_nxt   = 8'd0;
          w_lives_nxt   = c_LIVES;
          w_mole_nxt    = 7'd0;
          w_pat_req_nxt = 1'b1;
          w_state_nxt   = S_REQ;
        end
      end
      S_REQ: begin
        w_pat_req_nxt = 1'b1;
        // A zero pattern would show nothing, so such an ack is dropped.
        if (i_pat_ack && (i_pat_in != 7'd0)) begin
          w_mole_nxt    = i_pat_in;
          w_rcnt_nxt    = c_RBASE - c_RCNT_W'(r_level);
          w_presc_nxt   = '0;
          w_pat_req_nxt = 1'b0;
          w_state_nxt   = S_SHOW;
        end
      end
      S_SHOW: begin
        // Wrong press beats a simultaneous full hit.
        if ((w_hit_new & ~r_mole) != 7'd0) begin
          w_miss = 1'b1;
        end else if ((i_hit_btn & r_mole) == r_mole) begin
          w_score_nxt     = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
          w_hit_pulse_nxt = 1'b1;
          w_mole_nxt      = 7'd0;
          w_gcnt_nxt      = c_GAP;
          w_presc_nxt     = '0;
          w_state_nxt     = S_GAP;
        end else if (w_tick) begin
          if (r_rcnt == c_RCNT_ONE) w_miss = 1'b1;
          else                      w_rcnt_nxt = r_rcnt - c_RCNT_ONE;
        end
        if (w_miss) begin
          w_lives_nxt      = r_lives - 2'd1;
          w_miss_pulse_nxt = 1'b1;
          w_mole_nxt       = 7'd0;
          if (r_lives == 2'd1) begin
            w_hiscore_nxt = (r_score > r_hiscore) ? r_score : r_hiscore;
            w_state_nxt   = S_OVER;
          end else begin
            w_gcnt_nxt  = c_GAP;
            w_presc_nxt = '0;
            w_state_nxt = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (w_tick && (r_gcnt != '0)) w_gcnt_nxt = r_gcnt - c_GCNT_ONE;
        // Held buttons keep the gap open so a stale press cannot score.
        if ((r_gcnt == '0) && (i_hit_btn == 7'd0)) begin
          w_pat_req_nxt = 1'b1;
          w_state_nxt   = S_REQ;
        end
      end
      default: begin
        w_pat_req_nxt = 1'b0;
        w_mole_nxt    = 7'd0;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_start_q      <= 1'b0;
      r_hit_q        <= 7'd0;
      r_pat_req      <= 1'b0;
      r_mole         <= 7'd0;
      r_round_active <= 1'b0;
      r_score        <= 8'd0;
      r_hiscore      <= 8'd0;
      r_lives        <= 2'd0;
      r_level        <= 2'd0;
      r_game_over    <= 1'b0;
      r_hit_pulse    <= 1'b0;
      r_miss_pulse   <= 1'b0;
      r_rcnt         <= '0;
      r_gcnt         <= '0;
      r_presc        <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_start_q      <= i_start;
      r_hit_q        <= i_hit_btn;
      r_pat_req      <= w_pat_req_nxt;
      r_mole         <= w_mole_nxt;
      r_round_active <= (w_state_nxt == S_SHOW);
      r_score        <= w_score_nxt;
      r_hiscore      <= w_hiscore_nxt;
      r_lives        <= w_lives_nxt;
      r_level        <= level_of(w_score_nxt);
      r_game_over    <= (w_state_nxt == S_OVER);
      r_hit_pulse    <= w_hit_pulse_nxt;
      r_miss_pulse   <= w_miss_pulse_nxt;
      r_rcnt         <= w_rcnt_nxt;
      r_gcnt         <= w_gcnt_nxt;
      r_presc        <= w_presc_nxt;
    end
  end

  assign o_pat_req      = r_pat_req;
  assign o_mole         = r_mole;
  assign o_round_active = r_round_active;
  assign o_score        = r_score;
  assign o_hiscore      = r_hiscore;
  assign o_lives        = r_lives;
  assign o_level        = r_level;
  assign o_game_over    = r_game_over;
  assign o_hit_pulse    = r_hit_pulse;
  assign o_miss_pulse   = r_miss_pulse;

endmodule
`default_nettype wire

// File: doc/whack_round_scheduler.md
# whack_round_scheduler

Game session controller for the whack-a-mole design. It sequences a full game: start, per-round pattern request from the pattern generator, round timing with level-scaled duration, hit and miss judgement, lives, scoring, and high-score capture. It sits between the button inputs, the pattern generator (via a req/ack handshake) and the 7-segment and score drivers, and it replaces ad-hoc round sequencing with one explicit FSM.

## Interface
- TICK_DIV, 1000: clk cycles per game tick (1 ms at 1 MHz); ≥2
- ROUND_BASE, 5: round length in ticks at level 0; ≥4
- GAP_TICKS, 2: blank ticks between rounds; ≥1
- LIVES, 3: misses allowed per game; 1..3

- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  start request (level); rising edge is detected internally
- hit_btn  in  7  synchronized buttons, bit i = segment i
- pat_ack  in  1  pattern generator: pat_in valid this cycle
- pat_in  in  7  candidate pattern
- pat_req  out  1  request a new pattern
- mole  out  7  latched pattern shown to the player; 0 = blank
- round_active  out  1  high in SHOW
- score  out  8  current score, saturating
- hiscore  out  8  best score since rst
- lives  out  2  remaining lives
- level  out  2  difficulty level
- game_over  out  1  high in OVER
- hit_pulse, miss_pulse  out  1 each  one-cycle event strobes

## Operation
- States: IDLE, REQ, SHOW, GAP, OVER. All outputs are registered.
- start_edge = start & ~start_q; hit_new = hit_btn & ~hit_q. Both _q flops reset to 0.
- IDLE or OVER, on start_edge: score←0, lives←LIVES, mole←0, then go to REQ.
- REQ: pat_req=1 held until a cycle with pat_ack=1 and pat_in≠0. On that cycle: mole←pat_in, rcnt←ROUND_BASE−level, prescaler restarted, pat_req←0, go to SHOW. An ack with pat_in=0 is ignored and pat_req stays high.
- SHOW, evaluated each cycle in this priority:
  1. Wrong: hit_new & ~mole ≠ 0 → miss.
  2. Hit: (hit_btn & mole) == mole → score←min(score+1,255), hit_pulse, go to GAP.
  3. Timeout: a tick arrives with rcnt==1 → miss. Otherwise a tick decrements rcnt.
- Miss: lives←lives−1, miss_pulse. If the new lives value is 0, go to OVER; otherwise go to GAP.
- GAP: mole←0, gcnt←GAP_TICKS, prescaler restarted. Exit to REQ when gcnt has expired and hit_btn==0. If buttons are still held, stay in GAP.
- OVER: game_over=1, mole=0. On entry, hiscore←max(hiscore, score).
- level is derived from the registered score: 0 if score<5, 1 if <10, 2 if <20, 3 otherwise. It is sampled only when loading rcnt.
- Prescaler: counts 0..TICK_DIV−1 and emits a tick when it wraps. It is cleared on entry to SHOW and GAP.
- start_edge in REQ, SHOW or GAP is ignored.
- rst is valid in any state. It returns the block to IDLE with every output at its reset value.

## Timing
- Reset values: pat_req=0, mole=0, round_active=0, score=0, hiscore=0, lives=0, level=0, game_over=0, both pulses 0.
- start_edge in cycle t: state=REQ and pat_req=1 at t+1.
- Ack in cycle t: mole and round_active valid at t+1, and pat_req=0 at t+1.
- Timeout: miss_pulse is visible exactly (ROUND_BASE−level)·TICK_DIV cycles after round_active rises.
- Hit condition in cycle t: score increments and hit_pulse is high at t+1; state=GAP at t+1.
- GAP lasts at least GAP_TICKS·TICK_DIV cycles. pat_req rises one cycle after the gap expires with buttons released.
- Pulses are high for exactly one cycle.

## Test plan
- Reset/start (TICK_DIV=4): rst held, then start rises → all outputs 0 during reset; pat_req=1 one cycle after start; lives=3.
- Handshake: ack with pat_in=0, then ack with 7'b0000101 two cycles later → first ack ignored and pat_req stays high; mole=7'b0000101 and round_active=1 the cycle after the second ack.
- Hit: in SHOW with mole=7'b0000101, press bits 0 and 2 → hit_pulse once, score=1, mole=0. No new pat_req until the buttons are released and 8 cycles of gap have elapsed.
- Wrong press plus timeout: in SHOW press bit 6 → miss_pulse, lives=2. Next round with no press → miss_pulse exactly 20 cycles after round_active rises, lives=1.
- Wrong and hit in the same cycle: mole=7'b0000001, press bits 0 and 1 simultaneously → miss only (score unchanged, lives decremented).
- Game over and levels: drive score to 12 with hits, then miss 3 times → rcnt loads 3 at level 2; game_over=1, hiscore=12. A new start gives score=0 and hiscore stays 12. Asserting rst mid-SHOW gives hiscore=0 and state IDLE.
